imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 93 +++++++++
 tb/tb_imm_extend_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign / zero / upper) behind a 2-entry in-order result buffer.
// Optional macro IMM_EXTEND_LUI_EN enables Mode 10 (upper); otherwise Mode 10 flags Mode_err.
module imm_extend_pipe #(
  parameter int WL = 32,
  parameter int IW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] Imm,
  input  logic [1:0]    Mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] Simm,
  output logic          Mode_err
);

  typedef struct packed {
    logic          err;
    logic [WL-1:0] val;
  } res_t;

  res_t       ext_d;
  res_t       head_q, head_d;
  res_t       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_en_q;
  logic       push, pop;

  always_comb begin
    ext_d = '0;
    case (Mode)
      2'b00: begin
        ext_d.val[IW-1:0] = Imm;
        for (int i = IW; i < WL; i++) ext_d.val[i] = Imm[IW-1];
      end
      2'b01: ext_d.val[IW-1:0] = Imm;
`ifdef IMM_EXTEND_LUI_EN
      2'b10: ext_d.val[WL-1 -: IW] = Imm;
`else
      2'b10: ext_d.err = 1'b1;
`endif
      default: ext_d.err = 1'b1;
    endcase
  end

  // rdy_en_q keeps in_ready low through reset and the first edge after release
  assign in_ready  = rdy_en_q && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign Simm      = head_q.val;
  assign Mode_err  = head_q.err;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: if (push) begin
        head_d = ext_d;
        cnt_d  = 2'd1;
      end
      2'd1: begin
        if (push && pop) head_d = ext_d;
        else if (push) begin
          tail_d = ext_d;
          cnt_d  = 2'd2;
        end else if (pop) cnt_d = 2'd0;
      end
      default: if (pop) begin
        head_d = tail_q;
        cnt_d  = 2'd1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe (WL=32, IW=16); inputs driven on negedge.
module tb_imm_extend_pipe;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] Imm = '0;
  logic [1:0]  Mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Simm;
  logic        Mode_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  imm_extend_pipe #(.WL(32), .IW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .Imm(Imm), .Mode(Mode), .out_valid(out_valid), .out_ready(out_ready),
    .Simm(Simm), .Mode_err(Mode_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [15:0] imm, input logic [1:0] m);
    case (m)
      2'b00: return {1'b0, {16{imm[15]}}, imm};
      2'b01: return {1'b0, 16'h0000, imm};
`ifdef IMM_EXTEND_LUI_EN
      2'b10: return {1'b0, imm, 16'h0000};
`endif
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // record transfers that will happen on the coming edge, then advance one cycle
  task automatic tick();
    logic [32:0] e;
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(Imm, Mode));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious", 64'(out_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("simm", 64'(Simm), 64'(e[31:0]));
        chk("err", 64'(Mode_err), 64'(e[32]));
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("empty", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] hold;
    logic        done;

    // reset state
    #3;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd0);
    chk("rst_simm", 64'(Simm), 64'd0);
    chk("rst_err", 64'(Mode_err), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    in_valid = 1'b1; Imm = 16'h5555; Mode = 2'b00; out_ready = 1'b1;
    chk("rel_ir", 64'(in_ready), 64'd0);
    tick();
    chk("rel_ov", 64'(out_valid), 64'd0);
    chk("rel_ir1", 64'(in_ready), 64'd1);
    in_valid = 1'b0;

    // directed vectors, one at a time, latency 1
    begin
      logic [15:0] vi[5] = '{16'h8001, 16'h7FFF, 16'h8001, 16'h1234, 16'h1234};
      logic [1:0]  vm[5] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; Imm = vi[i]; Mode = vm[i];
        tick();
        in_valid = 1'b0;
        chk("lat_ov", 64'(out_valid), 64'd1);
        tick();
      end
    end
    chk("v_fixed", 64'(model(16'h8001, 2'b00)), 64'h0FFFF8001);
    drain();

    // stall: A,B accepted, C blocked, output stable
    out_ready = 1'b0; in_valid = 1'b1; Mode = 2'b00;
    Imm = 16'hA00A; tick();
    Imm = 16'h0B0B; Mode = 2'b01; tick();
    Imm = 16'hCCCC; Mode = 2'b00;
    chk("full_ir", 64'(in_ready), 64'd0);
    chk("full_ov", 64'(out_valid), 64'd1);
    hold = Simm;
    tick();
    chk("stable", 64'(Simm), 64'(hold));
    chk("full_ir2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      done = in_ready;
      tick();
    end
    chk("c_acc", 64'(done), 64'd1);
    drain();

    // streaming: 8 back-to-back
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Imm = 16'($urandom);
      Mode = 2'(i % 4);
      chk("strm_ir", 64'(in_ready), 64'd1);
      if (i > 0) chk("strm_ov", 64'(out_valid), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("strm_last", 64'(out_valid), 64'd1);
    tick();
    chk("strm_end", 64'(out_valid), 64'd0);
    chk("strm_q", 64'(exp_q.size()), 64'd0);

    // reset while full
    out_ready = 1'b0; in_valid = 1'b1; Mode = 2'b01;
    Imm = 16'h1111; tick();
    Imm = 16'h2222; tick();
    in_valid = 1'b0;
    chk("pre_full", 64'(in_ready), 64'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_ir", 64'(in_ready), 64'd0);
    chk("mrst_simm", 64'(Simm), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_ov", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; Imm = 16'hFFFE; Mode = 2'b00;
    tick();
    in_valid = 1'b0;
    chk("post_new", 64'(out_valid), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
